// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder:
// the FSM state encoding and the default error instruction.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] DEF_ERR_INSTR = 16'h0000;
  localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/imem_responder_array.sv
// Instruction storage: DEPTH x DATA_W words, synchronous write, combinational read.
// Contents are deliberately not reset.
module imem_array #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AW     = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Responder end of the instruction-fetch interface: returns the instruction for an
// accepted PC after LATENCY cycles, with valid/ready on both sides and a preload port.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 16,
  parameter int unsigned          DATA_W    = 16,
  parameter int unsigned          DEPTH     = 1024,
  parameter int unsigned          LATENCY   = 3,
  parameter logic [DATA_W-1:0]    ERR_INSTR = DATA_W'(DEF_ERR_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  localparam int unsigned      AW          = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LP_DEPTH   = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0] LP_CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_word;
  logic              r_err_cap;

  logic              w_accept;
  logic              w_req_err;
  logic              w_ld_ok;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_acc_word;
  logic [DATA_W-1:0] w_src_word;
  logic              w_src_err;
  logic              w_unused_ld_lsb;

  // Word index is the byte address >> 1; no wrap, anything at or past DEPTH is an error.
  assign w_req_err  = req_addr[0] | ({1'b0, req_addr[ADDR_W-1:1]} >= LP_DEPTH);
  assign w_ld_ok    = {1'b0, ld_addr[ADDR_W-1:1]} < LP_DEPTH;
  assign w_unused_ld_lsb = ld_addr[0];
  assign w_accept   = req_valid & req_ready;
  assign w_we       = ld_en & (r_state == IDLE) & ~w_accept & w_ld_ok;
  assign w_acc_word = w_req_err ? ERR_INSTR : w_rdata;
  assign busy       = (r_state != IDLE);

  imem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .waddr (ld_addr[AW:1]),
    .wdata (ld_data),
    .raddr (req_addr[AW:1]),
    .rdata (w_rdata)
  );

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = ~flush & ~rst;
        if (req_valid && req_ready) w_next = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        if (flush)              w_next = IDLE;
        else if (r_cnt == '0)   w_next = RESP;
      end
      RESP: begin
        if (flush || rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // With LATENCY==1 the response loads straight from the array at accept.
  assign w_src_word = (r_state == IDLE) ? w_acc_word : r_word;
  assign w_src_err  = (r_state == IDLE) ? w_req_err  : r_err_cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_word    <= '0;
      r_err_cap <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_err   <= 1'b0;
    end else begin
      r_state   <= w_next;
      rsp_valid <= (w_next == RESP);
      if (w_accept) begin
        r_cnt     <= LP_CNT_INIT;
        r_word    <= w_acc_word;
        r_err_cap <= w_req_err;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_next == RESP && r_state != RESP) begin
        rsp_instr <= w_src_word;
        rsp_err   <= w_src_err;
      end else if (w_next != RESP) begin
        rsp_instr <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed scoreboard bench for imem_responder (default parameters, LATENCY=3).
module tb_imem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_instr;
  logic        rsp_err;
  logic        flush;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;
  logic        busy;

  typedef struct {
    logic [15:0] instr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  imem_responder #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .DEPTH   (1024),
    .LATENCY (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] addr, input logic [15:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Present a request until accepted; returns at the first negedge after the accept edge.
  task automatic send(input logic [15:0] addr, input logic [15:0] e_instr, input logic e_err);
    int unsigned waitc = 0;
    req_valid = 1'b1; req_addr = addr;
    #1;
    while (!req_ready && waitc < 20) begin
      @(negedge clk); #1; waitc++;
    end
    check("req_accept", {31'd0, req_ready}, 32'd1);
    sb.push_back('{instr: e_instr, err: e_err});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, input int exp_lat);
    int lat = start;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk); lat++;
    end
    check("latency", lat, exp_lat);
  endtask

  // Compare the presented response with the scoreboard, then let the handshake complete.
  task automatic take();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_instr", {16'd0, rsp_instr}, {16'd0, e.instr});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_instr_zero", {16'd0, rsp_instr}, 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_instr", {16'd0, rsp_instr}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1. basic fetches
    load(16'h0000, 16'h1234);
    load(16'h0002, 16'h5678);
    load(16'h07FE, 16'hA5A5);
    send(16'h0000, 16'h1234, 1'b0); wait_rsp(1, 3); take();
    send(16'h0002, 16'h5678, 1'b0); wait_rsp(1, 3); take();

    // 2. backpressure
    rsp_ready = 1'b0;
    send(16'h0000, 16'h1234, 1'b0); wait_rsp(1, 3);
    repeat (5) begin
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_instr", {16'd0, rsp_instr}, 32'h1234);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    take();

    // 3. error cases
    send(16'h0003, 16'h0000, 1'b1); wait_rsp(1, 3); take();
    send(16'h0800, 16'h0000, 1'b1); wait_rsp(1, 3); take();
    send(16'h07FE, 16'hA5A5, 1'b0); wait_rsp(1, 3); take();

    // 4. flush during WAIT
    send(16'h0000, 16'h1234, 1'b0);
    void'(sb.pop_back());
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (6) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check("flush_no_rsp", seen, 0);
    send(16'h0002, 16'h5678, 1'b0); wait_rsp(1, 3); take();

    // 5. data sampled at accept; loads gated to IDLE
    send(16'h0000, 16'h1234, 1'b0);
    load(16'h0000, 16'hBEEF);
    wait_rsp(2, 3); take();
    load(16'h0000, 16'hBEEF);
    send(16'h0000, 16'hBEEF, 1'b0); wait_rsp(1, 3); take();
    load(16'h0005, 16'h3C3C);
    send(16'h0004, 16'h3C3C, 1'b0); wait_rsp(1, 3); take();
    load(16'h0800, 16'hDEAD);
    send(16'h0000, 16'hBEEF, 1'b0); wait_rsp(1, 3); take();

    // 6. async reset while a response is presented
    rsp_ready = 1'b0;
    send(16'h0002, 16'h5678, 1'b0); wait_rsp(1, 3);
    void'(sb.pop_back());
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_instr", {16'd0, rsp_instr}, 32'd0);
    check("arst_req_ready", {31'd0, req_ready}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("arst_hold_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("arst_release_ready", {31'd0, req_ready}, 32'd1);
    send(16'h0000, 16'hBEEF, 1'b0); wait_rsp(1, 3); take();
    send(16'h0002, 16'h5678, 1'b0); wait_rsp(1, 3); take();

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
